vga_timing_gen: RTL and testbench

//   Parametrised VGA raster timing generator. It is the successor to the fixed-mode

---
 rtl/vga_timing_gen.sv | 158 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: counters, syncs, blanking, DE and strobes.
// Optional 16-bit frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int   CNT_W    = 11,
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter logic H_POL    = 1'b1,
    parameter logic V_POL    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int     H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam longint CNT_RANGE = longint'(1) << CNT_W;

    generate
        if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
            V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_zero
            $fatal(1, "vga_timing_gen: every timing parameter must be non-zero");
        end
        if (longint'(H_TOTAL) > CNT_RANGE || longint'(V_TOTAL) > CNT_RANGE) begin : g_bad_width
            $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed the CNT_W counter range");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_BLANK_BEG  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_BLANK_BEG  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] hcount_d, hcount_q;
    logic [CNT_W-1:0] vcount_d, vcount_q;
    logic             hsync_d, hsync_q;
    logic             vsync_d, vsync_q;
    logic             hblnk_d, hblnk_q;
    logic             vblnk_d, vblnk_q;
    logic             de_d, de_q;
    logic             line_start_d, line_start_q;
    logic             frame_start_d, frame_start_q;

    // Flags decode the next counts so they line up with the registered counters.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (ce) begin
            if (hcount_q == H_LAST) begin
                hcount_d     = '0;
                line_start_d = 1'b1;
                if (vcount_q == V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 1'b1;
                end
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
        hblnk_d = (hcount_d >= H_BLANK_BEG);
        vblnk_d = (vcount_d >= V_BLANK_BEG);
        de_d    = ~hblnk_d & ~vblnk_d;
        hsync_d = ((hcount_d >= H_SYNC_BEG) && (hcount_d <= H_SYNC_END)) ? H_POL : ~H_POL;
        vsync_d = ((vcount_d >= V_SYNC_BEG) && (vcount_d <= V_SYNC_END)) ? V_POL : ~V_POL;
    end

    // Reset parks the raster on the last pixel so the first ce edge lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= H_LAST;
            vcount_q      <= V_LAST;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            hblnk_q       <= 1'b1;
            vblnk_q       <= 1'b1;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_d, frame_cnt_q;
    logic        first_seen_d, first_seen_q;

    // The first frame after reset is frame 0, so its strobe only arms the counter.
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        first_seen_d = first_seen_q;
        if (frame_start_d) begin
            first_seen_d = 1'b1;
            if (first_seen_q) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q  <= 16'd0;
            first_seen_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            first_seen_q <= first_seen_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance driven from a vector table,
// plus a tiny negative-polarity instance walked over whole frames.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce_d = 1'b0;
  logic ce_s = 1'b0;

  always #5 clk = ~clk;

  // default-timing instance
  logic [10:0] hc_d, vc_d;
  logic hs_d, vs_d, hb_d, vb_d, de_d, ls_d, fs_d;
  // small instance: H_TOTAL=16, V_TOTAL=8, negative syncs
  logic [4:0] hc_s, vc_s;
  logic hs_s, vs_s, hb_s, vb_s, de_s, ls_s, fs_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_d, fc_s;
`endif

  vga_timing_gen dut_d (
    .clk(clk), .rst_n(rst_n), .ce(ce_d),
    .hcount(hc_d), .vcount(vc_d), .hsync(hs_d), .vsync(vs_d),
    .hblnk(hb_d), .vblnk(vb_d), .de(de_d),
    .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_d)
`endif
  );

  vga_timing_gen #(
    .CNT_W(5), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .ce(ce_s),
    .hcount(hc_s), .vcount(vc_s), .hsync(hs_s), .vsync(vs_s),
    .hblnk(hb_s), .vblnk(vb_s), .de(de_s),
    .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_s)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // flags packed as {hsync, vsync, hblnk, vblnk, de, line_start, frame_start}
  typedef struct {
    int         n;
    logic       ce;
    int         h;
    int         v;
    logic [6:0] flags;
  } vec_t;

  vec_t vecs[22];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0,    1'b0, 1055, 627, 7'b0011000};
    vecs[1]  = '{1,    1'b1, 0,    0,   7'b0000111};
    vecs[2]  = '{1,    1'b1, 1,    0,   7'b0000100};
    vecs[3]  = '{798,  1'b1, 799,  0,   7'b0000100};
    vecs[4]  = '{1,    1'b1, 800,  0,   7'b0010000};
    vecs[5]  = '{39,   1'b1, 839,  0,   7'b0010000};
    vecs[6]  = '{1,    1'b1, 840,  0,   7'b1010000};
    vecs[7]  = '{127,  1'b1, 967,  0,   7'b1010000};
    vecs[8]  = '{1,    1'b1, 968,  0,   7'b0010000};
    vecs[9]  = '{87,   1'b1, 1055, 0,   7'b0010000};
    vecs[10] = '{1,    1'b1, 0,    1,   7'b0000110};
    vecs[11] = '{1,    1'b0, 0,    1,   7'b0000100};
    vecs[12] = '{1,    1'b1, 1,    1,   7'b0000100};
    vecs[13] = '{1,    1'b1, 2,    1,   7'b0000100};
    vecs[14] = '{1,    1'b0, 2,    1,   7'b0000100};
    vecs[15] = '{1,    1'b0, 2,    1,   7'b0000100};
    vecs[16] = '{1,    1'b1, 3,    1,   7'b0000100};
    vecs[17] = '{1052, 1'b1, 1055, 1,   7'b0010000};
    vecs[18] = '{1,    1'b0, 1055, 1,   7'b0010000};
    vecs[19] = '{1,    1'b1, 0,    2,   7'b0000110};
    vecs[20] = '{1,    1'b0, 0,    2,   7'b0000100};
    vecs[21] = '{1,    1'b1, 1,    2,   7'b0000100};

    // clock/reset
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // small instance: reset values, idle-high syncs
    check("s_rst_h", 32'(hc_s), 32'd15);
    check("s_rst_v", 32'(vc_s), 32'd7);
    check("s_rst_flags", 32'({hs_s, vs_s, hb_s, vb_s, de_s, ls_s, fs_s}), 32'(7'b1111000));

    // three full frames plus one edge, compared against the raster formulas
    for (int k = 0; k <= 384; k++) begin
      int         eh, ev;
      logic [6:0] ef;
      ce_s = 1'b1;
      @(posedge clk);
      #1;
      eh = k % 16;
      ev = (k / 16) % 8;
      ef[6] = !(eh >= 10 && eh <= 12);
      ef[5] = !(ev >= 5 && ev <= 6);
      ef[4] = (eh >= 8);
      ef[3] = (ev >= 4);
      ef[2] = !(eh >= 8) && !(ev >= 4);
      ef[1] = (eh == 0);
      ef[0] = (eh == 0) && (ev == 0);
      check($sformatf("s_h k=%0d", k), 32'(hc_s), 32'(eh));
      check($sformatf("s_v k=%0d", k), 32'(vc_s), 32'(ev));
      check($sformatf("s_flags k=%0d", k),
            32'({hs_s, vs_s, hb_s, vb_s, de_s, ls_s, fs_s}), 32'(ef));
`ifdef VGA_TIMING_FRAME_CNT_EN
      check($sformatf("s_frame_cnt k=%0d", k), 32'(fc_s), 32'(k / 128));
`endif
    end

    // ce low right after a frame start: strobes drop, counts and levels hold
    ce_s = 1'b0;
    @(posedge clk);
    #1;
    check("s_hold_h", 32'(hc_s), 32'd0);
    check("s_hold_v", 32'(vc_s), 32'd0);
    check("s_hold_flags", 32'({hs_s, vs_s, hb_s, vb_s, de_s, ls_s, fs_s}), 32'(7'b1100100));

`ifdef VGA_TIMING_FRAME_CNT_EN
    force dut_s.frame_cnt_q = 16'hFFFF;
    #1;
    release dut_s.frame_cnt_q;
    check("s_frame_cnt_forced", 32'(fc_s), 32'hFFFF);
    ce_s = 1'b1;
    repeat (128) @(posedge clk);
    #1;
    ce_s = 1'b0;
    check("s_wrap_fs", 32'(fs_s), 32'd1);
    check("s_frame_cnt_wrap", 32'(fc_s), 32'd0);
`endif

    // default instance: table-driven walk along the first lines
    for (int i = 0; i < 22; i++) begin
      repeat (vecs[i].n) begin
        ce_d = vecs[i].ce;
        @(posedge clk);
        #1;
      end
      ce_d = 1'b0;
      check($sformatf("d_h vec%0d", i), 32'(hc_d), 32'(vecs[i].h));
      check($sformatf("d_v vec%0d", i), 32'(vc_d), 32'(vecs[i].v));
      check($sformatf("d_flags vec%0d", i),
            32'({hs_d, vs_d, hb_d, vb_d, de_d, ls_d, fs_d}), 32'(vecs[i].flags));
    end

    // mid-line asynchronous reset at hcount=400
    ce_d = 1'b1;
    repeat (399) @(posedge clk);
    #1;
    ce_d = 1'b0;
    check("d_pre_rst_h", 32'(hc_d), 32'd400);
    #2;
    rst_n = 1'b0;
    #1;
    check("d_async_rst_h", 32'(hc_d), 32'd1055);
    check("d_async_rst_v", 32'(vc_d), 32'd627);
    check("d_async_rst_flags", 32'({hs_d, vs_d, hb_d, vb_d, de_d, ls_d, fs_d}), 32'(7'b0011000));
    check("s_async_rst_h", 32'(hc_s), 32'd15);
    check("s_async_rst_sync", 32'({hs_s, vs_s}), 32'(2'b11));
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("d_async_rst_frame_cnt", 32'(fc_d), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ce_d  = 1'b1;
    @(posedge clk);
    #1;
    check("d_restart_h", 32'(hc_d), 32'd0);
    check("d_restart_v", 32'(vc_d), 32'd0);
    check("d_restart_flags", 32'({hs_d, vs_d, hb_d, vb_d, de_d, ls_d, fs_d}), 32'(7'b0000111));
    @(posedge clk);
    #1;
    ce_d = 1'b0;
    check("d_restart_h1", 32'(hc_d), 32'd1);
    check("d_restart_flags1", 32'({hs_d, vs_d, hb_d, vb_d, de_d, ls_d, fs_d}), 32'(7'b0000100));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
